// File: rtl/branch_decode_pipe.sv
// Decodes LANES branch/jump slots per bundle into a 2-entry output+skid buffer.
// Latency 1 cycle when empty; in_ready is registered and drops only while the skid entry is full.
module branch_decode_pipe #(
  parameter int LANES = 2,
  parameter int IMM_W = 22
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*32-1:0]    in_inst,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES-1:0]       is_nop,
  output logic [LANES-1:0]       is_jmp,
  output logic [LANES-1:0]       is_imm_type,
  output logic [LANES-1:0]       zero_ext,
  output logic [LANES-1:0]       illegal,
  output logic [LANES*2-1:0]     op,
  output logic [LANES*5-1:0]     rs1,
  output logic [LANES*5-1:0]     rs2,
  output logic [LANES*5-1:0]     rd,
  output logic [LANES*IMM_W-1:0] imm,
  output logic [15:0]            illegal_cnt
);

  typedef struct packed {
    logic             is_nop;
    logic             is_jmp;
    logic             is_imm_type;
    logic             zero_ext;
    logic             illegal;
    logic [1:0]       op;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [IMM_W-1:0] imm;
  } lane_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_t;

  function automatic lane_t decode_lane(input logic [31:0] w);
    lane_t      d;
    logic [2:0] f3;
    d        = '0;
    f3       = w[14:12];
    d.rs1    = w[19:15];
    d.rs2    = w[24:20];
    d.rd     = w[11:7];
    d.is_nop = (w == 32'h0);
    case (w[6:0])
      7'b1100011: begin
        if (f3 == 3'd2 || f3 == 3'd3) begin
          d.illegal = 1'b1;
        end else begin
          // funct3 0/1/4/5/6/7 collapse onto {signed-vs-eq class, sense}
          d.op       = {f3[2], f3[0]};
          d.zero_ext = f3[2] & f3[1];
          d.imm      = IMM_W'($signed({w[31], w[7], w[30:25], w[11:8]}));
        end
      end
      7'b1101111: begin
        d.is_jmp = 1'b1;
        d.imm    = IMM_W'($signed({w[31], w[19:12], w[20], w[30:21]}));
      end
      7'b1100111: begin
        d.is_jmp      = 1'b1;
        d.is_imm_type = 1'b1;
        d.imm         = IMM_W'($signed(w[31:20]));
      end
      default: d.illegal = ~d.is_nop;
    endcase
    return d;
  endfunction

  lane_t      dec    [LANES];
  lane_t      out_q  [LANES];
  lane_t      skid_q [LANES];
  occ_t       state, state_nxt;
  logic       accept, consume;
  logic       load_out, load_skid, out_from_skid;
  logic [3:0] n_ill;
  logic [16:0] cnt_sum;
  logic [15:0] cnt_nxt;

  always_comb begin
    n_ill = '0;
    for (int k = 0; k < LANES; k++) begin
      dec[k] = decode_lane(in_inst[32*k +: 32]);
      n_ill  = n_ill + {3'b000, dec[k].illegal};
    end
  end

  assign cnt_sum   = {1'b0, illegal_cnt} + {13'd0, n_ill};
  assign cnt_nxt   = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;

  always_comb begin
    state_nxt     = state;
    load_out      = 1'b0;
    load_skid     = 1'b0;
    out_from_skid = 1'b0;
    case (state)
      EMPTY: if (accept) begin
        state_nxt = ONE;
        load_out  = 1'b1;
      end
      ONE: begin
        if (accept && consume) begin
          load_out = 1'b1;
        end else if (accept) begin
          state_nxt = TWO;
          load_skid = 1'b1;
        end else if (consume) begin
          state_nxt = EMPTY;
        end
      end
      TWO: if (consume) begin
        state_nxt     = ONE;
        out_from_skid = 1'b1;
      end
      default: state_nxt = EMPTY;
    endcase
    // Flush wins over everything, including a same-cycle acceptance.
    if (flush) begin
      state_nxt     = EMPTY;
      load_out      = 1'b0;
      load_skid     = 1'b0;
      out_from_skid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= EMPTY;
      in_ready    <= 1'b0;
      illegal_cnt <= '0;
      for (int k = 0; k < LANES; k++) begin
        out_q[k]  <= '0;
        skid_q[k] <= '0;
      end
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != TWO);
      if (accept && !flush) illegal_cnt <= cnt_nxt;
      for (int k = 0; k < LANES; k++) begin
        if (load_out)           out_q[k] <= dec[k];
        else if (out_from_skid) out_q[k] <= skid_q[k];
        if (load_skid)          skid_q[k] <= dec[k];
      end
    end
  end

  always_comb begin
    is_nop = '0; is_jmp = '0; is_imm_type = '0; zero_ext = '0; illegal = '0;
    op = '0; rs1 = '0; rs2 = '0; rd = '0; imm = '0;
    for (int k = 0; k < LANES; k++) begin
      is_nop[k]              = out_q[k].is_nop;
      is_jmp[k]              = out_q[k].is_jmp;
      is_imm_type[k]         = out_q[k].is_imm_type;
      zero_ext[k]            = out_q[k].zero_ext;
      illegal[k]             = out_q[k].illegal;
      op[2*k +: 2]           = out_q[k].op;
      rs1[5*k +: 5]          = out_q[k].rs1;
      rs2[5*k +: 5]          = out_q[k].rs2;
      rd[5*k +: 5]           = out_q[k].rd;
      imm[IMM_W*k +: IMM_W]  = out_q[k].imm;
    end
  end

endmodule
